// File: rtl/sha256_padder_pkg.sv
// Shared types, block geometry constants and the byte-lane pad/fill helper
// for the SHA-256 message padder.
package sha256_pkg;

  localparam int BLOCK_BITS     = 512;
  localparam int BLOCK_BYTES    = 64;
  localparam int LEN_FIELD_BITS = 64;
  localparam int LEN_START_BYTE = 56;

  localparam logic [7:0] PAD_BYTE = 8'h80;

  typedef enum logic [1:0] {
    S_LOAD = 2'd0,
    S_FIN  = 2'd1,
    S_LEN  = 2'd2,
    S_OUT  = 2'd3
  } padder_state_t;

  // Bytes below ptr are kept, ptr gets the marker, the rest are zeroed;
  // optionally the length overwrites the last eight bytes.
  function automatic logic [BLOCK_BITS-1:0] pad_fill(
    input logic [BLOCK_BITS-1:0]     blk,
    input logic [5:0]                ptr,
    input logic [LEN_FIELD_BITS-1:0] len,
    input logic                      with_len
  );
    logic [BLOCK_BITS-1:0] res;
    res = blk;
    for (int i = 0; i < BLOCK_BYTES; i++) begin
      if (6'(i) == ptr) begin
        res[BLOCK_BITS-1-8*i -: 8] = PAD_BYTE;
      end else if (6'(i) > ptr) begin
        res[BLOCK_BITS-1-8*i -: 8] = 8'h00;
      end else begin
        res[BLOCK_BITS-1-8*i -: 8] = blk[BLOCK_BITS-1-8*i -: 8];
      end
    end
    if (with_len) begin
      res[LEN_FIELD_BITS-1:0] = len;
    end else begin
      res = res;
    end
    return res;
  endfunction

endpackage

// File: rtl/sha256_padder_if.sv
// Byte-in / block-out handshake bundle of the SHA-256 padder.
interface sha256_padder_if;
  import sha256_pkg::*;

  logic                  in_valid;
  logic [7:0]            in_data;
  logic                  in_keep;
  logic                  in_last;
  logic                  in_ready;
  logic                  blk_valid;
  logic [BLOCK_BITS-1:0] blk_data;
  logic                  blk_last;
  logic                  blk_ready;
  logic                  err_ovf;

  modport master (
    output in_valid, in_data, in_keep, in_last, blk_ready,
    input  in_ready, blk_valid, blk_data, blk_last, err_ovf
  );

  modport slave (
    input  in_valid, in_data, in_keep, in_last, blk_ready,
    output in_ready, blk_valid, blk_data, blk_last, err_ovf
  );

endinterface

// File: rtl/sha256_padder.sv
// SHA-256 padder: packs bytes into 512-bit blocks, appends marker and length.
// Optional feature macro: SHA256_PADDER_OVF_EN (saturating count, sticky err_ovf).
module sha256_padder
  import sha256_pkg::*;
#(
  parameter int LEN_W = 32
) (
  input  logic          clock,
  input  logic          reset,
  sha256_padder_if.slave bus
);

  padder_state_t             state_r;
  logic [5:0]                ptr_r;
  logic [LEN_W-1:0]          count_r;
  logic [BLOCK_BITS-1:0]     buf_r;
  logic                      in_ready_r;
  logic                      blk_valid_r;
  logic                      blk_last_r;
  logic                      fin_pend_r;
  logic                      len_pend_r;

  logic                      accept_s;
  logic                      fits_s;
  logic [LEN_W-1:0]          count_next_s;
  logic [LEN_FIELD_BITS-1:0] len_s;

  // Beat acceptance, next byte count and the 64-bit bit-length field.
  always_comb begin
    accept_s = bus.in_valid && in_ready_r && (state_r == S_LOAD);
    fits_s   = (ptr_r <= 6'(LEN_START_BYTE - 1));
    len_s    = '0;
    len_s[LEN_W+2:0] = {count_r, 3'b000};
`ifdef SHA256_PADDER_OVF_EN
    if (&count_r) begin
      count_next_s = count_r;
    end else begin
      count_next_s = count_r + LEN_W'(1);
    end
`else
    count_next_s = count_r + LEN_W'(1);
`endif
  end

  // Padder FSM with all datapath and handshake registers.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_r     <= S_LOAD;
      ptr_r       <= 6'd0;
      count_r     <= '0;
      buf_r       <= '0;
      in_ready_r  <= 1'b0;
      blk_valid_r <= 1'b0;
      blk_last_r  <= 1'b0;
      fin_pend_r  <= 1'b0;
      len_pend_r  <= 1'b0;
    end else begin
      case (state_r)
        S_LOAD: begin
          in_ready_r <= 1'b1;
          if (accept_s) begin
            if (bus.in_keep) begin
              buf_r[{~ptr_r, 3'b000} +: 8] <= bus.in_data;
              ptr_r   <= ptr_r + 6'd1;
              count_r <= count_next_s;
              if (ptr_r == 6'd63) begin
                // Full block: a pending final beat finishes after this block drains.
                state_r     <= S_OUT;
                blk_valid_r <= 1'b1;
                blk_last_r  <= 1'b0;
                in_ready_r  <= 1'b0;
                ptr_r       <= 6'd0;
                fin_pend_r  <= bus.in_last;
              end else if (bus.in_last) begin
                state_r    <= S_FIN;
                in_ready_r <= 1'b0;
              end else begin
                state_r <= S_LOAD;
              end
            end else if (bus.in_last) begin
              state_r    <= S_FIN;
              in_ready_r <= 1'b0;
            end else begin
              state_r <= S_LOAD;
            end
          end
        end
        S_FIN: begin
          buf_r       <= pad_fill(buf_r, ptr_r, len_s, fits_s);
          blk_last_r  <= fits_s;
          len_pend_r  <= !fits_s;
          blk_valid_r <= 1'b1;
          in_ready_r  <= 1'b0;
          state_r     <= S_OUT;
        end
        S_LEN: begin
          buf_r       <= {{(BLOCK_BITS-LEN_FIELD_BITS){1'b0}}, len_s};
          blk_last_r  <= 1'b1;
          len_pend_r  <= 1'b0;
          blk_valid_r <= 1'b1;
          in_ready_r  <= 1'b0;
          state_r     <= S_OUT;
        end
        S_OUT: begin
          if (bus.blk_ready) begin
            blk_valid_r <= 1'b0;
            if (len_pend_r) begin
              state_r <= S_LEN;
            end else if (fin_pend_r) begin
              state_r    <= S_FIN;
              ptr_r      <= 6'd0;
              fin_pend_r <= 1'b0;
            end else if (blk_last_r) begin
              state_r    <= S_LOAD;
              ptr_r      <= 6'd0;
              count_r    <= '0;
              blk_last_r <= 1'b0;
              in_ready_r <= 1'b1;
            end else begin
              state_r    <= S_LOAD;
              ptr_r      <= 6'd0;
              in_ready_r <= 1'b1;
            end
          end
        end
        default: begin
          state_r     <= S_LOAD;
          in_ready_r  <= 1'b0;
          blk_valid_r <= 1'b0;
        end
      endcase
    end
  end

`ifdef SHA256_PADDER_OVF_EN
  logic err_ovf_r;

  // Sticky flag: a byte arrived while the counter was already saturated.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      err_ovf_r <= 1'b0;
    end else if (accept_s && bus.in_keep && (&count_r)) begin
      err_ovf_r <= 1'b1;
    end else begin
      err_ovf_r <= err_ovf_r;
    end
  end

  assign bus.err_ovf = err_ovf_r;
`else
  assign bus.err_ovf = 1'b0;
`endif

  assign bus.in_ready  = in_ready_r;
  assign bus.blk_valid = blk_valid_r;
  assign bus.blk_data  = buf_r;
  assign bus.blk_last  = blk_last_r;

endmodule
